unidad_control_multiciclo: RTL and testbench

Multicycle RISC-V (RV32I subset) control unit; the stage directly upstream of the register file.
- Sequences Fetch/Decode/Execute/Memory/Writeback per instruction.
- Generates the register-file write enable (`reg_write`), memory/IR/PC enables and datapath mux selects.
- Consumes opcode/funct fields from the instruction register and the ALU `zero` flag.

---
 rtl/uc_pkg.sv | 93 +++++++++
 rtl/alu_decoder.sv | 44 ++++
 rtl/unidad_control_multiciclo.sv | 219 +++++++++++++++++++++
 tb/tb_unidad_control_multiciclo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uc_pkg
//  Description : Shared definitions for the multicycle RV32I control unit:
//                FSM state encoding, opcode constants, ALU operation and
//                control codes, immediate-format codes, datapath mux select
//                codes, the per-state control bundle and an imm_src helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uc_pkg;

    // FSM states; four bits leave encodings 11..15 unused (treated as illegal)
    typedef enum logic [3:0] {
        S0_FETCH     = 4'd0,
        S1_DECODE    = 4'd1,
        S2_MEMADR    = 4'd2,
        S3_MEMREAD   = 4'd3,
        S4_MEMWB     = 4'd4,
        S5_MEMWRITE  = 4'd5,
        S6_EXECUTER  = 4'd6,
        S7_ALUWB     = 4'd7,
        S8_EXECUTEI  = 4'd8,
        S9_JAL       = 4'd9,
        S10_BEQ      = 4'd10
    } state_t;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALU operation class handed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Datapath mux selects
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RD1      = 2'b10;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Control bundle produced purely from the current state
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       reg_write;
    } ctrl_t;

    // Immediate format is a pure function of the opcode; unknown -> I-type
    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Combinational ALU decoder. Maps the FSM's ALU operation class
//                and the instruction funct fields to an ALU control code.
//  Ports       : aluop[1:0]       - 00 add, 01 sub, 10 use funct fields
//                funct3[2:0]      - instr[14:12]
//                funct7b5         - instr[30]
//                op5              - instr[5], separates R-type from I-type
//                alu_control[2:0] - ALU operation select
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import uc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // instr[30] only means sub for R-type; for addi it is
                    // part of the immediate and must be ignored
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : unidad_control_multiciclo
//  Description : Multicycle RV32I-subset control unit. Moore FSM sequencing
//                fetch/decode/execute/memory/writeback and driving the
//                register-file, memory, IR and PC enables plus datapath
//                mux selects.
//  Ports       : clk, reset (async, active high)
//                op, funct3, funct7b5   - instruction register fields
//                zero                   - ALU zero flag
//                pc_write, adr_src, mem_write, ir_write, result_src,
//                alu_src_a, alu_src_b, imm_src, alu_control, reg_write
//                illegal_op             - pulse in DECODE on unsupported op
//                instr_count[31:0]      - retired-instruction counter
//                                         (only with UC_INSTR_COUNT_EN)
//  Options     : UC_INSTR_COUNT_EN adds the instr_count output and counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module unidad_control_multiciclo
    import uc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         NUM_STATES  = 11
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [2:0]  alu_control,
    output logic        reg_write,
    output logic        illegal_op
`ifdef UC_INSTR_COUNT_EN
    ,
    output logic [31:0] instr_count
`endif
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    logic   w_state_legal;
    logic   w_op_supported;

    assign w_state_legal  = ({28'd0, r_state} < NUM_STATES[31:0]);
    assign w_op_supported = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                            (op == OP_I)  || (op == OP_JAL) || (op == OP_BEQ);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = S0_FETCH;
        if (w_state_legal) begin
            case (r_state)
                S0_FETCH:    w_next_state = S1_DECODE;
                S1_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: w_next_state = S2_MEMADR;
                        OP_R:         w_next_state = S6_EXECUTER;
                        OP_I:         w_next_state = S8_EXECUTEI;
                        OP_JAL:       w_next_state = S9_JAL;
                        OP_BEQ:       w_next_state = S10_BEQ;
                        default:      w_next_state = S0_FETCH;
                    endcase
                end
                S2_MEMADR:   w_next_state = (op == OP_SW) ? S5_MEMWRITE : S3_MEMREAD;
                S3_MEMREAD:  w_next_state = S4_MEMWB;
                S4_MEMWB:    w_next_state = S0_FETCH;
                S5_MEMWRITE: w_next_state = S0_FETCH;
                S6_EXECUTER: w_next_state = S7_ALUWB;
                S7_ALUWB:    w_next_state = S0_FETCH;
                S8_EXECUTEI: w_next_state = S7_ALUWB;
                S9_JAL:      w_next_state = S7_ALUWB;
                S10_BEQ:     w_next_state = S0_FETCH;
                default:     w_next_state = S0_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State-decoded control bundle (Moore). Unlisted fields stay zero, so
    // unused encodings fall out with every enable deasserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S0_FETCH: begin
                w_ctrl.adr_src    = ADR_PC;
                w_ctrl.ir_write   = 1'b1;
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.aluop      = ALUOP_ADD;
                w_ctrl.result_src = RES_ALURESULT;
                w_ctrl.pc_update  = 1'b1;
            end
            S1_DECODE: begin
                // Precompute the branch target from OldPC + immediate
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.aluop      = ALUOP_ADD;
            end
            S2_MEMADR: begin
                w_ctrl.alu_src_a  = SRCA_RD1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.aluop      = ALUOP_ADD;
            end
            S3_MEMREAD: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.adr_src    = ADR_ALUOUT;
            end
            S4_MEMWB: begin
                w_ctrl.result_src = RES_DATA;
                w_ctrl.reg_write  = 1'b1;
            end
            S5_MEMWRITE: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.adr_src    = ADR_ALUOUT;
                w_ctrl.mem_write  = 1'b1;
            end
            S6_EXECUTER: begin
                w_ctrl.alu_src_a  = SRCA_RD1;
                w_ctrl.alu_src_b  = SRCB_RD2;
                w_ctrl.aluop      = ALUOP_FUNCT;
            end
            S7_ALUWB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
            end
            S8_EXECUTEI: begin
                w_ctrl.alu_src_a  = SRCA_RD1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.aluop      = ALUOP_FUNCT;
            end
            S9_JAL: begin
                // Return address OldPC + 4 is computed while the PC loads
                // the jump target held in ALUOut from DECODE
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.aluop      = ALUOP_ADD;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_update  = 1'b1;
            end
            S10_BEQ: begin
                w_ctrl.alu_src_a  = SRCA_RD1;
                w_ctrl.alu_src_b  = SRCB_RD2;
                w_ctrl.aluop      = ALUOP_SUB;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.branch     = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop       (w_ctrl.aluop),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

    // Selects pass straight through; the state register is already FETCH
    // while reset is high, so they show their FETCH values. Enables are
    // gated with reset so nothing is written during reset.
    assign adr_src    = w_ctrl.adr_src;
    assign result_src = w_ctrl.result_src;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign imm_src    = imm_src_for(op);

    assign pc_write   = ~reset & (w_ctrl.pc_update | (w_ctrl.branch & zero));
    assign mem_write  = ~reset & w_ctrl.mem_write;
    assign ir_write   = ~reset & w_ctrl.ir_write;
    assign reg_write  = ~reset & w_ctrl.reg_write;
    assign illegal_op = ~reset & (r_state == S1_DECODE) & ~w_op_supported;

`ifdef UC_INSTR_COUNT_EN
    logic [31:0] r_instr_count;
    logic        w_retire;

    // An instruction retires when its final state hands back to FETCH
    assign w_retire = (w_next_state == S0_FETCH) &&
                      ((r_state == S4_MEMWB) || (r_state == S5_MEMWRITE) ||
                       (r_state == S7_ALUWB) || (r_state == S10_BEQ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_count <= 32'd0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unidad_control_multiciclo
//  Description : Self-checking bench for unidad_control_multiciclo. A state
//                model predicts the full output vector each cycle; the
//                prediction is queued and compared at the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unidad_control_multiciclo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  op = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7b5 = 1'b0;
    logic        zero = 1'b0;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
`ifdef UC_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    always #5 clk = ~clk;

    unidad_control_multiciclo dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .reg_write   (reg_write),
        .illegal_op  (illegal_op)
`ifdef UC_INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    logic [16:0] w_obs;
    assign w_obs = {pc_write, adr_src, mem_write, ir_write, result_src,
                    alu_src_a, alu_src_b, imm_src, alu_control, reg_write, illegal_op};

    logic [16:0] exp_q[$];
    int n_vec   = 0;
    int n_err   = 0;
    int ms      = 0;
    int exp_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] exp_vec(input int s, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7,
                                            input logic z, input logic r);
        logic pcu, br, adr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb, imm, aop;
        logic [2:0] alu;
        pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        res = 0; sa = 0; sb = 0; aop = 0;
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        case (s)
            0:  begin irw = 1; sb = 2; res = 2; pcu = 1; end
            1:  begin sa = 1; sb = 1;
                      ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011,
                                        7'b0010011, 7'b1101111, 7'b1100011}); end
            2:  begin sa = 2; sb = 1; end
            3:  begin adr = 1; end
            4:  begin res = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; sb = 0; aop = 2; end
            7:  begin rw = 1; end
            8:  begin sa = 2; sb = 1; aop = 2; end
            9:  begin sa = 1; sb = 2; pcu = 1; end
            10: begin sa = 2; aop = 1; br = 1; end
            default: ;
        endcase
        if (aop == 1) alu = 3'b001;
        else if (aop == 2) begin
            case (f3)
                3'b000:  alu = (o[5] && f7) ? 3'b001 : 3'b000;
                3'b010:  alu = 3'b101;
                3'b110:  alu = 3'b011;
                3'b111:  alu = 3'b010;
                default: alu = 3'b000;
            endcase
        end else alu = 3'b000;
        if (r) begin pcu = 0; br = 0; mw = 0; irw = 0; rw = 0; ill = 0; end
        return {pcu | (br & z), adr, mw, irw, res, sa, sb, imm, alu, rw, ill};
    endfunction

    function automatic int next_state(input int s, input logic [6:0] o);
        case (s)
            0: return 1;
            1: case (o)
                   7'b0000011, 7'b0100011: return 2;
                   7'b0110011: return 6;
                   7'b0010011: return 8;
                   7'b1101111: return 9;
                   7'b1100011: return 10;
                   default:    return 0;
               endcase
            2: return (o == 7'b0100011) ? 5 : 3;
            3: return 4;
            6, 8, 9: return 7;
            default: return 0;
        endcase
    endfunction

    // One clock: queue prediction, compare at negedge, advance model at posedge
    task automatic run_cycle();
        logic [16:0] e;
        int nxt;
        exp_q.push_back(exp_vec(ms, op, funct3, funct7b5, zero, reset));
        @(negedge clk);
        e = exp_q.pop_front();
        check_val($sformatf("out_s%0d_op%b", ms, op), {15'd0, w_obs}, {15'd0, e});
        @(posedge clk);
        if (reset) ms = 0;
        else begin
            nxt = next_state(ms, op);
            if (nxt == 0 && (ms == 4 || ms == 5 || ms == 7 || ms == 10)) exp_cnt++;
            ms = nxt;
        end
        #1;
    endtask

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int cpi);
        int cyc;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        cyc = 0;
        do begin
            run_cycle();
            cyc++;
        end while (ms != 0 && cyc < 20);
        check_val({name, "_cpi"}, cyc, cpi);
`ifdef UC_INSTR_COUNT_EN
        check_val({name, "_cnt"}, instr_count, exp_cnt);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        op = 7'b0000011;
        repeat (2) @(posedge clk);
        #1;
        run_cycle();                                  // outputs held under reset
        reset = 1'b0;

        run_instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b1, 5);
        run_instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b1, 4);
        run_instr("r_sub",   7'b0110011, 3'b000, 1'b1, 1'b1, 4);
        run_instr("r_add",   7'b0110011, 3'b000, 1'b0, 1'b0, 4);
        run_instr("r_slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 4);
        run_instr("r_or",    7'b0110011, 3'b110, 1'b0, 1'b0, 4);
        run_instr("r_and",   7'b0110011, 3'b111, 1'b0, 1'b0, 4);
        run_instr("addi_b30",7'b0010011, 3'b000, 1'b1, 1'b0, 4);
        run_instr("i_f3_001",7'b0010011, 3'b001, 1'b0, 1'b0, 4);
        run_instr("slti",    7'b0010011, 3'b010, 1'b0, 1'b1, 4);
        run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b1, 4);
        run_instr("beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1, 3);
        run_instr("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, 3);
        run_instr("ill_ff",  7'b1111111, 3'b000, 1'b0, 1'b0, 2);
        run_instr("ill_lui", 7'b0110111, 3'b000, 1'b0, 1'b1, 2);

        // Reset asserted part-way through MEMREAD and held three cycles
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) run_cycle();
        #2;
        reset = 1'b1;
        ms = 0;
        exp_cnt = 0;
        #1;
        check_val("rst_async", {15'd0, w_obs},
                  {15'd0, exp_vec(0, op, funct3, funct7b5, zero, 1'b1)});
        repeat (3) run_cycle();
        reset = 1'b0;

        run_instr("lw_post", 7'b0000011, 3'b010, 1'b0, 1'b0, 5);
        run_instr("sw_post", 7'b0100011, 3'b010, 1'b0, 1'b0, 4);
        run_instr("beq_post",7'b1100011, 3'b000, 1'b0, 1'b1, 3);
`ifdef UC_INSTR_COUNT_EN
        check_val("cnt_three", instr_count, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
